instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage of the core: holds the PC, issues single-outstanding requests to instruction memory, and registers each returned word.
- Presents the word to decode with a valid/ready handshake, together with its PC and a 3-bit predecoded instr_type.
- instr_type uses the immediate-generator encoding, so the immediate generator consumes instr_out and instr_type directly.
- Accepts PC redirects (branch/jump/trap) from execute and squashes any wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, byte increment applied after each accepted fetch

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  request to instruction memory; held until imem_ack
imem_addr  output  32  fetch address; stable while imem_req=1
imem_ack  input  1  one-cycle pulse, imem_rdata valid in same cycle
imem_rdata  input  32  returned instruction word
instr_valid  output  1  instr_out/pc_out/instr_type valid to decode
instr_ready  input  1  decode accepts current instruction
instr_out  output  32  registered instruction word
pc_out  output  32  PC of instr_out
instr_type  output  3  predecoded format
redirect_valid  input  1  one-cycle redirect request
redirect_target  input  32  new PC
fetch_fault  output  1  misaligned-target flag (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values (applied when rst=1 at a clk edge; overrides all other inputs):
  - pc=RESET_PC, state=FETCH
  - imem_req=0, imem_addr=RESET_PC
  - instr_valid=0, instr_out=0, pc_out=0, instr_type=3'b111, fetch_fault=0
- First request: imem_req=1 in the first cycle after rst deasserts.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack with no redirect: instr_out<=imem_rdata, pc_out<=pc, instr_type<=predecode(imem_rdata), instr_valid<=1, pc<=pc+PC_STEP (mod 2^32; 0xFFFF_FFFC wraps to 0), state<=HOLD, imem_req<=0.
  - Latency: ack cycle N gives instr_valid=1 at cycle N+1.
- State HOLD:
  - imem_req=0; outputs stay stable while instr_valid=1 and instr_ready=0.
  - instr_ready=1: instr_valid<=0, state<=FETCH (next request issued the following cycle).
  - Peak throughput: one instruction per 2 cycles with zero-wait memory.
- State DRAIN:
  - imem_req stays 1 with the old imem_addr until imem_ack; the acked data is discarded.
  - After the ack: state<=FETCH at the redirected pc.
- Redirect (priority over imem_ack and instr_ready):
  - pc<=redirect_target and instr_valid<=0 in every state.
  - FETCH without same-cycle ack: state<=DRAIN (memory protocol forbids dropping req).
  - FETCH with same-cycle ack: data discarded, state<=FETCH with new address next cycle.
  - HOLD: held instruction squashed, even if instr_ready=1 in the same cycle; state<=FETCH.
  - DRAIN: pc updated again (last redirect wins), stay DRAIN.
- Predecode, opcode = bits[6:0]:
  - 0010011/0000011/1100111/1110011 -> 000 (I)
  - 0100011 -> 001 (S)
  - 0110011 -> 010 (R)
  - 0110111/0010111 -> 011 (U)
  - 1100011 -> 101 (B)
  - 1101111 -> 110 (J)
  - any other -> 111
- imem_rdata is sampled only in the imem_ack cycle; rdata without ack is ignored.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_target[1:0]!=0 sets fetch_fault<=1; pc is loaded with the target but no fetch is issued.
  - The unit enters state FAULT: imem_req=0, instr_valid=0. Any pending DRAIN completes first.
  - Only rst or an aligned redirect clears fetch_fault and resumes FETCH.
- Undefined: fetch_fault is tied to 0; the target is used with bits[1:0] forced to 0.

Test Plan:
- Reset sequence, zero-wait memory (ack the cycle after req), instr_ready=1: imem_addr sequence 0x0,0x4,0x8; instr_valid pulses with pc_out 0x0,0x4,0x8.
- Backpressure: rdata=0x00500093, instr_ready=0 for 5 cycles -> instr_valid=1 with instr_out=0x00500093 and instr_type=000 held stable; no imem_req until ready.
- Redirect while ack outstanding: req at 0x10, redirect to 0x200 with ack 3 cycles later -> old data never appears on instr_out; next imem_addr=0x200.
- Redirect same cycle as instr_ready in HOLD -> instruction dropped; pc_out of the next valid is 0x200.
- Predecode sweep: rdata 0x00002023, 0xFE000EE3, 0x0080006F, 0x00000033 -> instr_type 001, 101, 110, 010.
- FETCH_ALIGN_CHECK_EN defined, redirect to 0x102 -> fetch_fault=1 and imem_req=0 until a redirect to 0x100, which clears the fault and fetches 0x100.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, issues single-outstanding requests to
// instruction memory, registers each returned word with its PC and
// predecoded immediate-format type, and hands it to decode via valid/ready.
// Redirects from execute replace the PC and squash any wrong-path fetch.
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned redirect target
// raises fetch_fault and parks the unit until rst or an aligned redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [2:0]  instr_type,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        valid_n;
  logic        fault_n;
  logic        capture;
  logic        ack_ok;
  logic [31:0] tgt;
  logic        misaligned;

  // Map an opcode onto the immediate-generator format encoding.
  function automatic logic [2:0] predecode(input logic [31:0] word);
    logic [2:0] t;
    case (word[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: t = 3'b000;
      7'b0100011:                                     t = 3'b001;
      7'b0110011:                                     t = 3'b010;
      7'b0110111, 7'b0010111:                         t = 3'b011;
      7'b1100011:                                     t = 3'b101;
      7'b1101111:                                     t = 3'b110;
      default:                                        t = 3'b111;
    endcase
    return t;
  endfunction

  // An ack only counts while a request is actually outstanding.
  assign ack_ok = imem_ack & imem_req;

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt        = redirect_target;
  assign misaligned = |redirect_target[1:0];
`else
  assign tgt        = redirect_target & ~32'h3;
  assign misaligned = 1'b0;
`endif

  // Next-state, next-PC and capture decisions; redirect outranks ack/ready.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = instr_valid;
    fault_n = fetch_fault;
    capture = 1'b0;
    case (state)
      FETCH: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          valid_n = 1'b0;
          fault_n = misaligned;
          // A request already on the bus must be acked before moving on;
          // the post-reset cycle has no request out, so nothing to drain.
          if (ack_ok || !imem_req) state_n = misaligned ? FAULT : FETCH;
          else                     state_n = DRAIN;
        end else if (ack_ok) begin
          capture = 1'b1;
          valid_n = 1'b1;
          pc_n    = pc + PC_STEP;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          valid_n = 1'b0;
          fault_n = misaligned;
          state_n = misaligned ? FAULT : FETCH;
        end else if (instr_ready) begin
          valid_n = 1'b0;
          state_n = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          fault_n = misaligned;
        end
        if (ack_ok) state_n = fault_n ? FAULT : FETCH;
      end
      FAULT: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          fault_n = misaligned;
          state_n = misaligned ? FAULT : FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // State, PC, memory-request and decode-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_type  <= 3'b111;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_valid <= valid_n;
      fetch_fault <= fault_n;
      imem_req    <= (state_n == FETCH) || (state_n == DRAIN);
      // DRAIN keeps the old address on the bus until its ack arrives.
      if (state_n == FETCH) imem_addr <= pc_n;
      if (capture) begin
        instr_out  <= imem_rdata;
        pc_out     <= pc;
        instr_type <= predecode(imem_rdata);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory handshakes, backpressure,
// redirects in each state, predecode formats, PC wrap and alignment fault.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [2:0]  instr_type;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_fault;

  int unsigned total = 0;
  int unsigned bad   = 0;

  instruction_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (32'd4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_type     (instr_type),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle ack with data, as a zero-wait memory would give.
  task automatic mem_ack(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hA5A5_A5A5;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid  = 1'b1;
    redirect_target = target;
    tick();
    redirect_valid  = 1'b0;
    redirect_target = '0;
  endtask

  initial begin
    rst             = 1'b1;
    imem_ack        = 1'b0;
    imem_rdata      = '0;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    tick();
    tick();
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_pc",    pc_out, 32'h0);
    check("rst_type",  32'(instr_type), 32'd7);
    check("rst_fault", 32'(fetch_fault), 32'd0);

    // Zero-wait stream with decode always ready.
    rst = 1'b0;
    tick();
    check("s0_req",  32'(imem_req), 32'd1);
    check("s0_addr", imem_addr, 32'h0);
    mem_ack(32'h0000_0013);
    check("s0_valid", 32'(instr_valid), 32'd1);
    check("s0_pc",    pc_out, 32'h0);
    check("s0_instr", instr_out, 32'h0000_0013);
    check("s0_type",  32'(instr_type), 32'd0);
    check("s0_noreq", 32'(imem_req), 32'd0);
    tick();
    check("s1_valid", 32'(instr_valid), 32'd0);
    check("s1_req",   32'(imem_req), 32'd1);
    check("s1_addr",  imem_addr, 32'h4);
    mem_ack(32'h0000_2023);
    check("s1_pc",   pc_out, 32'h4);
    check("s1_type", 32'(instr_type), 32'd1);
    tick();
    check("s2_addr", imem_addr, 32'h8);
    mem_ack(32'hFE00_0EE3);
    check("s2_valid", 32'(instr_valid), 32'd1);
    check("s2_pc",    pc_out, 32'h8);
    check("s2_type",  32'(instr_type), 32'd5);
    tick();
    check("s3_addr", imem_addr, 32'hC);

    // Backpressure: held output stable, no request, stray rdata ignored.
    instr_ready = 1'b0;
    mem_ack(32'h0050_0093);
    for (int i = 0; i < 5; i++) begin
      imem_rdata = 32'h0000_006F + 32'(i);
      tick();
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_instr", instr_out, 32'h0050_0093);
      check("bp_type",  32'(instr_type), 32'd0);
      check("bp_pc",    pc_out, 32'hC);
      check("bp_noreq", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    check("bp_rel_valid", 32'(instr_valid), 32'd0);
    check("bp_rel_req",   32'(imem_req), 32'd1);
    check("bp_rel_addr",  imem_addr, 32'h10);

    // Redirect with the 0x10 request outstanding; ack comes 3 cycles later.
    redirect(32'h200);
    for (int i = 0; i < 2; i++) begin
      check("dr_req",   32'(imem_req), 32'd1);
      check("dr_addr",  imem_addr, 32'h10);
      check("dr_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    mem_ack(32'hDEAD_BEEF);
    check("dr_done_valid", 32'(instr_valid), 32'd0);
    check("dr_done_instr", instr_out, 32'h0050_0093);
    check("dr_done_req",   32'(imem_req), 32'd1);
    check("dr_done_addr",  imem_addr, 32'h200);
    mem_ack(32'h0080_006F);
    check("j_valid", 32'(instr_valid), 32'd1);
    check("j_pc",    pc_out, 32'h200);
    check("j_type",  32'(instr_type), 32'd6);
    tick();
    check("j_next_addr", imem_addr, 32'h204);

    // Redirect in HOLD in the same cycle as instr_ready squashes the word.
    instr_ready = 1'b0;
    mem_ack(32'h0000_0033);
    check("r_pc",   pc_out, 32'h204);
    check("r_type", 32'(instr_type), 32'd2);
    instr_ready = 1'b1;
    redirect(32'h200);
    instr_ready = 1'b0;
    check("sq_valid", 32'(instr_valid), 32'd0);
    check("sq_req",   32'(imem_req), 32'd1);
    check("sq_addr",  imem_addr, 32'h200);
    mem_ack(32'h0000_0037);
    check("u_valid", 32'(instr_valid), 32'd1);
    check("u_pc",    pc_out, 32'h200);
    check("u_instr", instr_out, 32'h0000_0037);
    check("u_type",  32'(instr_type), 32'd3);

    // Redirect coinciding with ack in FETCH: data dropped, refetch at target.
    instr_ready = 1'b1;
    tick();
    check("ra_addr0", imem_addr, 32'h204);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    redirect(32'h40);
    imem_ack   = 1'b0;
    check("ra_valid", 32'(instr_valid), 32'd0);
    check("ra_instr", instr_out, 32'h0000_0037);
    check("ra_req",   32'(imem_req), 32'd1);
    check("ra_addr",  imem_addr, 32'h40);
    instr_ready = 1'b0;
    mem_ack(32'h0000_007F);
    check("x_pc",   pc_out, 32'h40);
    check("x_type", 32'(instr_type), 32'd7);

    // PC wraps from the top of the address space.
    redirect(32'hFFFF_FFFC);
    check("w_addr", imem_addr, 32'hFFFF_FFFC);
    mem_ack(32'h0000_0013);
    check("w_pc", pc_out, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    tick();
    check("w_next_addr", imem_addr, 32'h0);
    instr_ready = 1'b0;
    mem_ack(32'h0000_0013);
    check("w_next_pc", pc_out, 32'h0);

    // Misaligned redirect from HOLD.
    redirect(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      check("f_fault", 32'(fetch_fault), 32'd1);
      check("f_noreq", 32'(imem_req), 32'd0);
      check("f_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    redirect(32'h100);
`endif
    check("al_fault", 32'(fetch_fault), 32'd0);
    check("al_req",   32'(imem_req), 32'd1);
    check("al_addr",  imem_addr, 32'h100);
    mem_ack(32'h0000_0013);
    check("al_pc", pc_out, 32'h100);

    // Reset mid-operation.
    rst = 1'b1;
    tick();
    check("rr_valid", 32'(instr_valid), 32'd0);
    check("rr_req",   32'(imem_req), 32'd0);
    check("rr_pc",    pc_out, 32'h0);
    check("rr_type",  32'(instr_type), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
